// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory arbiter.
// state_t    : arbiter sequencer states
// WORD_BYTES : bytes per memory word
// ADDR_LSB   : byte-address bits below the word index
// is_illegal : access legality check (alignment, range, ROM write)
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam int unsigned WORD_BYTES = 8;
  localparam int unsigned ADDR_LSB   = 3;

  function automatic logic is_illegal(input logic [31:0] addr, input logic we,
                                      input int unsigned mem_size,
                                      input int unsigned rom_size);
    logic [31:0] word;
    word = addr >> ADDR_LSB;
    return (addr[ADDR_LSB-1:0] != '0) || (word >= mem_size) || (we && (word < rom_size));
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of requester handshakes and data-memory bus for dmem_arbiter.
// Requester side : req_valid/req_ready/req_addr/req_we/req_wdata,
//                  rsp_valid/rsp_ready/rsp_rdata/rsp_err
// Memory side    : mem_addr/mem_wr_data/mem_wr_enable/mem_rd_enable/mem_rd_data
// modport master : the arbiter (drives responses and the memory bus)
// modport slave  : the surroundings (requesters and memory)
interface dmem_arbiter_if #(
  parameter int unsigned NREQ = 2
);

  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*32-1:0] req_addr;
  logic [NREQ-1:0]    req_we;
  logic [NREQ*64-1:0] req_wdata;
  logic [NREQ-1:0]    rsp_valid;
  logic [NREQ-1:0]    rsp_ready;
  logic [63:0]        rsp_rdata;
  logic               rsp_err;
  logic [31:0]        mem_addr;
  logic [63:0]        mem_wr_data;
  logic               mem_wr_enable;
  logic               mem_rd_enable;
  logic [63:0]        mem_rd_data;

  modport master (
    input  req_valid, req_addr, req_we, req_wdata, rsp_ready, mem_rd_data,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           mem_addr, mem_wr_data, mem_wr_enable, mem_rd_enable
  );

  modport slave (
    output req_valid, req_addr, req_we, req_wdata, rsp_ready, mem_rd_data,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           mem_addr, mem_wr_data, mem_wr_enable, mem_rd_enable
  );

endinterface

// File: rtl/dmem_arbiter_rr.sv
// Round-robin grant for NREQ requesters.
// clk, rst_n : clock, asynchronous active-low reset (pointer returns to port 0)
// req        : per-port request vector
// advance    : a grant was taken this cycle; pointer moves past the winner
// grant      : one-hot grant (first requesting port at or after the pointer)
// win        : index of the granted port
module rr_arbiter #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            advance,
  output logic [NREQ-1:0] grant,
  output logic [PW-1:0]   win
);

  logic [PW-1:0] ptr;
  logic          found;
  int unsigned   idx;

  always_comb begin
    grant = '0;
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      idx = (32'(ptr) + off) % NREQ;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        win        = PW'(idx);
        found      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= PW'((32'(win) + 1) % NREQ);
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for the single-ported 64-bit data memory.
// clk, rst_n : clock, asynchronous active-low reset
// bus        : requester handshakes, shared response and memory bus
// One transaction at a time: accept (IDLE) -> one-cycle strobe (ISSUE) ->
// held response (RESP). Illegal accesses skip ISSUE and never touch memory.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned MEM_SIZE = 256,
  parameter int unsigned ROM_SIZE = 4,
  parameter int unsigned NREQ     = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  dmem_arbiter_if.master  bus
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t          state;
  logic [PW-1:0]   id;
  logic            we_q;
  logic [NREQ-1:0] grant;
  logic [PW-1:0]   win;
  logic            accept;
  logic [31:0]     win_addr;
  logic            win_we;
  logic [63:0]     win_wdata;
  logic            win_err;

  rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_rr (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (bus.req_valid),
    .advance (accept),
    .grant   (grant),
    .win     (win)
  );

  // Only the granted port's payload is ever looked at.
  assign win_addr  = bus.req_addr[32*win +: 32];
  assign win_we    = bus.req_we[win];
  assign win_wdata = bus.req_wdata[64*win +: 64];
  assign win_err   = is_illegal(win_addr, win_we, MEM_SIZE, ROM_SIZE);

  assign accept        = (state == IDLE) && (grant != '0);
  assign bus.req_ready = (state == IDLE) ? grant : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      id                <= '0;
      we_q              <= 1'b0;
      bus.rsp_valid     <= '0;
      bus.rsp_rdata     <= '0;
      bus.rsp_err       <= 1'b0;
      bus.mem_addr      <= '0;
      bus.mem_wr_data   <= '0;
      bus.mem_wr_enable <= 1'b0;
      bus.mem_rd_enable <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            id   <= win;
            we_q <= win_we;
            if (win_err) begin
              state         <= RESP;
              bus.rsp_valid <= NREQ'(1) << win;
              bus.rsp_err   <= 1'b1;
              bus.rsp_rdata <= '0;
            end else begin
              state             <= ISSUE;
              bus.mem_addr      <= win_addr;
              bus.mem_wr_data   <= win_wdata;
              bus.mem_wr_enable <= win_we;
              bus.mem_rd_enable <= !win_we;
            end
          end
        end
        ISSUE: begin
          bus.mem_addr      <= '0;
          bus.mem_wr_data   <= '0;
          bus.mem_wr_enable <= 1'b0;
          bus.mem_rd_enable <= 1'b0;
          bus.rsp_rdata     <= we_q ? '0 : bus.mem_rd_data;
          bus.rsp_err       <= 1'b0;
          bus.rsp_valid     <= NREQ'(1) << id;
          state             <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready[id]) begin
            bus.rsp_valid <= '0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  logic clk;
  logic rst_n;

  dmem_arbiter_if #(.NREQ(2)) bus ();

  dmem_arbiter #(.MEM_SIZE(256), .ROM_SIZE(4), .NREQ(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Requester-side drive (one slot per port)
  logic        vld [2];
  logic [31:0] adr [2];
  logic        wen [2];
  logic [63:0] wd  [2];
  logic [1:0]  rrdy;
  bit          rand_rdy;

  assign bus.req_valid = {vld[1], vld[0]};
  assign bus.req_addr  = {adr[1], adr[0]};
  assign bus.req_we    = {wen[1], wen[0]};
  assign bus.req_wdata = {wd[1], wd[0]};
  assign bus.rsp_ready = rrdy;

  // Memory behind the arbiter
  logic [63:0] tb_mem [256];
  assign bus.mem_rd_data = tb_mem[bus.mem_addr[10:3]];
  always @(posedge clk) if (bus.mem_wr_enable) tb_mem[bus.mem_addr[10:3]] <= bus.mem_wr_data;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h required %h", name, got, exp);
    end
  endtask

  task automatic fail(input string name, input string why);
    checks++;
    errors++;
    $display("FAIL %s %s", name, why);
  endtask

  // Reference model: transaction-level view of the arbiter
  typedef struct {
    int          port;
    logic [63:0] rdata;
    logic        err;
    int          first_cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          acc_log[$];
  logic [63:0] ref_mem [256];
  int          cyc = 0;
  int          acc_cyc = 0;
  int          rr = 0;
  bit          busy = 0;
  bit          rsp_seen = 0;
  bit          exp_strobe = 0;
  logic [31:0] s_addr;
  logic        s_we;
  logic [63:0] s_wdata;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      int          w;
      logic [1:0]  exp_rdy;
      logic [1:0]  rv;
      exp_t        e;
      w = -1;
      exp_rdy = 2'b00;
      if (!busy) begin
        if (vld[rr]) w = rr;
        else if (vld[1-rr]) w = 1 - rr;
        if (w >= 0) exp_rdy = 2'b01 << w;
      end
      chk("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
      if (w >= 0) begin
        int unsigned word;
        bit          err;
        word = adr[w] / 8;
        err  = (adr[w] % 8 != 0) || (word >= 256) || (wen[w] && word < 4);
        e.port  = w;
        e.err   = err;
        e.rdata = (err || wen[w]) ? 64'd0 : ref_mem[word];
        e.first_cyc = cyc + 1 + (err ? 0 : 1);
        if (!err && wen[w]) ref_mem[word] = wd[w];
        exp_q.push_back(e);
        acc_log.push_back(w);
        acc_cyc    = cyc + 1;
        exp_strobe = !err;
        s_addr     = adr[w];
        s_we       = wen[w];
        s_wdata    = wd[w];
        rr         = 1 - w;
        busy       = 1;
      end

      if (bus.mem_wr_enable || bus.mem_rd_enable) begin
        if (!exp_strobe || cyc != acc_cyc) begin
          fail("mem_strobe", $sformatf("got strobe wr=%0b rd=%0b addr %h, required none", bus.mem_wr_enable, bus.mem_rd_enable, bus.mem_addr));
        end else begin
          chk("mem_addr", 64'(bus.mem_addr), 64'(s_addr));
          chk("mem_wr_enable", 64'(bus.mem_wr_enable), 64'(s_we));
          chk("mem_rd_enable", 64'(bus.mem_rd_enable), 64'(!s_we));
          if (s_we) chk("mem_wr_data", bus.mem_wr_data, s_wdata);
        end
        exp_strobe = 0;
      end else if (exp_strobe && cyc >= acc_cyc) begin
        fail("mem_strobe", $sformatf("got no strobe, required access at %h", s_addr));
        exp_strobe = 0;
      end

      rv = bus.rsp_valid;
      if (exp_q.size() == 0) begin
        if (rv != 2'b00) fail("rsp_valid", $sformatf("got %b, required 00", rv));
      end else begin
        e = exp_q[0];
        if (rv != 2'b00) begin
          if (!rsp_seen) begin
            chk("rsp_latency", 64'(cyc), 64'(e.first_cyc));
            rsp_seen = 1;
          end
          chk("rsp_valid", 64'(rv), 64'(2'b01 << e.port));
          chk("rsp_rdata", bus.rsp_rdata, e.rdata);
          chk("rsp_err", 64'(bus.rsp_err), 64'(e.err));
          if (rrdy[e.port]) begin
            void'(exp_q.pop_front());
            rsp_seen = 0;
            busy = 0;
          end
        end else if (cyc > e.first_cyc) begin
          fail("rsp_valid", $sformatf("got 00, required response on port %0d", e.port));
          void'(exp_q.pop_front());
          rsp_seen = 0;
          busy = 0;
        end
      end
    end
  end

  task automatic issue(input int p, input logic [31:0] a, input logic w, input logic [63:0] d);
    bit got;
    vld[p] = 1'b1;
    adr[p] = a;
    wen[p] = w;
    wd[p]  = d;
    got = 0;
    for (int n = 0; n < 300 && !got; n++) begin
      @(negedge clk);
      if (bus.req_ready[p]) got = 1;
    end
    if (!got) fail("accept_timeout", $sformatf("port %0d got no req_ready, required within 300 cycles", p));
    @(posedge clk);
    #1;
    vld[p] = 1'b0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 0;
    for (int n = 0; n < 300 && !done; n++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0) done = 1;
    end
    if (!done) fail("drain_timeout", $sformatf("got %0d responses pending, required 0", exp_q.size()));
    @(posedge clk);
    #1;
  endtask

  task automatic rand_port(input int p, input int count);
    logic [31:0] a;
    int unsigned word;
    for (int i = 0; i < count; i++) begin
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
      word = $urandom_range(0, 259);
      a = word << 3;
      if ($urandom_range(0, 7) == 0) a = a + $urandom_range(1, 7);
      issue(p, a, 1'($urandom), {$urandom, $urandom});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got no completion, required finish within 200000 time units");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      vld[i] = 1'b0;
      adr[i] = '0;
      wen[i] = 1'b0;
      wd[i]  = '0;
    end
    rrdy = 2'b11;
    rand_rdy = 0;
    for (int i = 0; i < 256; i++) begin
      logic [63:0] v;
      v = {$urandom, $urandom};
      tb_mem[i]  = v;
      ref_mem[i] = v;
    end
    tb_mem[4]  = 64'hDEADBEEF_00000001;
    ref_mem[4] = 64'hDEADBEEF_00000001;

    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("reset_rsp_rdata", bus.rsp_rdata, 64'd0);
    chk("reset_rsp_err", 64'(bus.rsp_err), 64'd0);
    chk("reset_mem_addr", 64'(bus.mem_addr), 64'd0);
    chk("reset_mem_strobes", 64'({bus.mem_wr_enable, bus.mem_rd_enable}), 64'd0);
    chk("reset_req_ready", 64'(bus.req_ready), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed single read, write/read-back, illegal accesses
    issue(0, 32'h20, 1'b0, 64'd0);
    wait_idle();
    issue(1, 32'h28, 1'b1, 64'h11223344_55667788);
    wait_idle();
    issue(1, 32'h28, 1'b0, 64'd0);
    wait_idle();
    issue(0, 32'h08, 1'b1, 64'hCAFE);
    wait_idle();
    issue(0, 32'h21, 1'b0, 64'd0);
    wait_idle();
    issue(1, 32'h800, 1'b0, 64'd0);
    wait_idle();

    // Async reset while a read is in ISSUE; pointer left favouring port 1
    issue(0, 32'h30, 1'b0, 64'd0);
    begin
      bit seen;
      seen = 0;
      for (int n = 0; n < 20 && !seen; n++) begin
        if (bus.mem_rd_enable) seen = 1;
        else @(negedge clk);
      end
      if (!seen) fail("reset_issue", "got no read strobe, required one before reset");
    end
    #2 rst_n = 1'b0;
    busy = 0;
    exp_q.delete();
    exp_strobe = 0;
    rsp_seen = 0;
    rr = 0;
    #1;
    chk("async_rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("async_rst_mem_strobes", 64'({bus.mem_wr_enable, bus.mem_rd_enable}), 64'd0);
    chk("async_rst_mem_addr", 64'(bus.mem_addr), 64'd0);
    chk("async_rst_rsp_rdata", bus.rsp_rdata, 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Contention: grants must alternate starting from port 0
    acc_log.delete();
    fork
      begin
        for (int i = 0; i < 3; i++) issue(0, 32'h100 + 32'(i * 8), 1'b0, 64'd0);
      end
      begin
        for (int i = 0; i < 3; i++) issue(1, 32'h200 + 32'(i * 8), 1'b1, {32'hA5A5_0000, 32'(i)});
      end
    join
    wait_idle();
    chk("contention_count", 64'(acc_log.size()), 64'd6);
    for (int i = 0; i < acc_log.size() && i < 6; i++)
      chk($sformatf("contention_grant%0d", i), 64'(acc_log[i]), 64'(i % 2));

    // Response backpressure on port 0 while port 1 waits
    rrdy = 2'b00;
    fork
      issue(0, 32'h20, 1'b0, 64'd0);
      issue(1, 32'h40, 1'b0, 64'd0);
      begin
        repeat (8) @(posedge clk);
        #1 rrdy = 2'b11;
      end
    join
    wait_idle();

    // Randomized traffic with random response backpressure
    rand_rdy = 1;
    fork
      rand_port(0, 20);
      rand_port(1, 20);
    join
    rand_rdy = 0;
    rrdy = 2'b11;
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) rrdy = {1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0)};
    end
  end

endmodule
